// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 memory responder: access FSM states and the I/O address.
package lc3_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam logic [15:0] IO_HEX_ADDR = 16'hFFFF;
  localparam int          CNT_W       = 4;

  function automatic logic is_io(input logic [15:0] addr);
    return addr == IO_HEX_ADDR;
  endfunction

endpackage

// File: rtl/lc3_sram_array.sv
// 2^AW x 16 storage with synchronous write and registered read; one-cycle read latency, no backpressure.
// Contents are deliberately left unreset.
module lc3_sram_array #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [15:0]   wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [15:0]   rd_data
);

  logic [15:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/lc3_mem_responder.sv
// LC-3 memory responder: SRAM plus FFFF switch/hex I/O, response WAIT_STATES cycles after accept.
// Single outstanding access; req_ready only in IDLE, responses are a one-cycle pulse with no backpressure.
module lc3_mem_responder
  import lc3_mem_pkg::*;
#(
  parameter int WAIT_STATES = 2,
  parameter int AW          = 8
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  input  logic [15:0] SW,
  output logic [15:0] HEX_reg
);

  localparam logic [CNT_W-1:0] WS_LOAD = CNT_W'(WAIT_STATES);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic        accept;
  logic        enter_resp;
  logic        we_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic [15:0] sw_q;
  logic [15:0] rdata_hold;

  logic        cur_we;
  logic        cur_io;
  logic [15:0] cur_addr;
  logic [15:0] cur_wdata;
  logic [15:0] sram_rdata;
  logic [15:0] rsp_mux;
  logic        sram_wr_en;
  logic        sram_rd_en;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;

  // With zero wait states the access completes on the accept edge, so use the live request then.
  assign cur_we    = (state == IDLE) ? req_we    : we_q;
  assign cur_addr  = (state == IDLE) ? req_addr  : addr_q;
  assign cur_wdata = (state == IDLE) ? req_wdata : wdata_q;
  assign cur_io    = is_io(cur_addr);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (WAIT_STATES > 0) begin
            state_nxt = WAIT;
            cnt_nxt   = WS_LOAD;
          end else begin
            state_nxt = RESP;
          end
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 1'b1;
        if (cnt == CNT_W'(1)) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign enter_resp = (state_nxt == RESP) && Reset_n;
  assign sram_wr_en = enter_resp && cur_we && !cur_io;
  assign sram_rd_en = enter_resp && !cur_we && !cur_io;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      sw_q    <= '0;
    end else if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      if (!req_we && is_io(req_addr)) sw_q <= SW;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      HEX_reg <= '0;
    end else if (enter_resp && cur_we && cur_io) begin
      HEX_reg <= cur_wdata;
    end
  end

  lc3_sram_array #(
    .AW(AW)
  ) u_sram (
    .clk     (Clk),
    .wr_en   (sram_wr_en),
    .wr_addr (cur_addr[AW-1:0]),
    .wr_data (cur_wdata),
    .rd_en   (sram_rd_en),
    .rd_addr (cur_addr[AW-1:0]),
    .rd_data (sram_rdata)
  );

  assign rsp_mux = we_q ? wdata_q : (is_io(addr_q) ? sw_q : sram_rdata);

  // Snapshot the response as RESP ends so the output holds it until the next one.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rdata_hold <= '0;
    end else if (state == RESP) begin
      rdata_hold <= rsp_mux;
    end
  end

  assign rsp_valid = (state == RESP);
  assign rsp_rdata = (state == RESP) ? rsp_mux : rdata_hold;

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Directed bench for lc3_mem_responder: WAIT_STATES=2 instance (a) and WAIT_STATES=0 instance (b).
module tb_lc3_mem_responder;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b1;
  logic [15:0] SW = 16'h0000;

  logic        a_req_valid = 1'b0, a_req_we = 1'b0;
  logic [15:0] a_req_addr = '0, a_req_wdata = '0;
  logic        a_req_ready, a_rsp_valid;
  logic [15:0] a_rsp_rdata, a_HEX_reg;

  logic        b_req_valid = 1'b0, b_req_we = 1'b0;
  logic [15:0] b_req_addr = '0, b_req_wdata = '0;
  logic        b_req_ready, b_rsp_valid;
  logic [15:0] b_rsp_rdata, b_HEX_reg;

  always #5 Clk = ~Clk;

  lc3_mem_responder #(.WAIT_STATES(2), .AW(8)) dut_a (
    .Clk(Clk), .Reset_n(Reset_n),
    .req_valid(a_req_valid), .req_we(a_req_we), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .req_ready(a_req_ready), .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata),
    .SW(SW), .HEX_reg(a_HEX_reg)
  );

  lc3_mem_responder #(.WAIT_STATES(0), .AW(8)) dut_b (
    .Clk(Clk), .Reset_n(Reset_n),
    .req_valid(b_req_valid), .req_we(b_req_we), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .req_ready(b_req_ready), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
    .SW(SW), .HEX_reg(b_HEX_reg)
  );

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboards: expected data and the cycle count seen at the negedge inside RESP.
  int qa_data[$], qa_cyc[$];
  int qb_data[$], qb_cyc[$];
  int ma_d, ma_c, mb_d, mb_c;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (Reset_n && a_rsp_valid) begin
      chk("a_rsp_expected", 32'(qa_data.size() != 0), 32'd1);
      if (qa_data.size() != 0) begin
        ma_d = qa_data.pop_front();
        ma_c = qa_cyc.pop_front();
        chk("a_rsp_rdata", 32'(a_rsp_rdata), 32'(ma_d));
        chk("a_rsp_cycle", 32'(cyc), 32'(ma_c));
        chk("a_ready_in_resp", 32'(a_req_ready), 32'd0);
      end
    end
    if (Reset_n && b_rsp_valid) begin
      chk("b_rsp_expected", 32'(qb_data.size() != 0), 32'd1);
      if (qb_data.size() != 0) begin
        mb_d = qb_data.pop_front();
        mb_c = qb_cyc.pop_front();
        chk("b_rsp_rdata", 32'(b_rsp_rdata), 32'(mb_d));
        chk("b_rsp_cycle", 32'(cyc), 32'(mb_c));
        chk("b_ready_in_resp", 32'(b_req_ready), 32'd0);
      end
    end
  end

  // sel=0 drives instance a (2 wait states), sel=1 drives instance b (0 wait states).
  task automatic req(input bit sel, input bit we, input logic [15:0] addr,
                     input logic [15:0] wdata, input logic [15:0] exp);
    int  c;
    bit  ok;
    ok = 1'b0;
    c  = 0;
    @(negedge Clk);
    if (sel) begin
      b_req_valid = 1'b1; b_req_we = we; b_req_addr = addr; b_req_wdata = wdata;
    end else begin
      a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr; a_req_wdata = wdata;
    end
    for (int i = 0; i < 40; i++) begin
      if (sel ? b_req_ready : a_req_ready) begin
        c  = cyc;
        ok = 1'b1;
        break;
      end
      @(negedge Clk);
    end
    chk("req_accept", 32'(ok), 32'd1);
    if (ok) begin
      if (sel) begin
        qb_data.push_back(int'(exp)); qb_cyc.push_back(c + 1);
      end else begin
        qa_data.push_back(int'(exp)); qa_cyc.push_back(c + 3);
      end
    end
    @(posedge Clk);
    #1;
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((qa_data.size() != 0 || qb_data.size() != 0) && n < 60) begin
      @(negedge Clk);
      n++;
    end
    chk("drain_pending", 32'(qa_data.size() + qb_data.size()), 32'd0);
    @(negedge Clk);
  endtask

  initial begin
    int c0;
    #1 Reset_n = 1'b0;
    #1;
    chk("rst_a_ready", 32'(a_req_ready), 32'd1);
    chk("rst_a_rsp_valid", 32'(a_rsp_valid), 32'd0);
    chk("rst_a_rdata", 32'(a_rsp_rdata), 32'h0);
    chk("rst_a_hex", 32'(a_HEX_reg), 32'h0);
    chk("rst_b_ready", 32'(b_req_ready), 32'd1);
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);

    // Write then read back through the 2-wait-state instance.
    req(0, 1'b1, 16'h0005, 16'h1234, 16'h1234);
    req(0, 1'b0, 16'h0005, 16'h0000, 16'h1234);
    drain();

    // Memory-mapped hex write and switch read.
    req(0, 1'b1, 16'hFFFF, 16'hBEEF, 16'hBEEF);
    drain();
    chk("hex_after_write", 32'(a_HEX_reg), 32'hBEEF);
    SW = 16'h00A5;
    req(0, 1'b0, 16'hFFFF, 16'h0000, 16'h00A5);
    drain();
    repeat (3) @(negedge Clk);
    chk("rdata_hold", 32'(a_rsp_rdata), 32'h00A5);
    chk("hex_after_io_read", 32'(a_HEX_reg), 32'hBEEF);

    // Upper address bits alias onto the same SRAM word.
    req(0, 1'b1, 16'h0105, 16'h7777, 16'h7777);
    req(0, 1'b0, 16'h0005, 16'h0000, 16'h7777);
    drain();

    // Continuous request with zero wait states: accept every second cycle.
    @(negedge Clk);
    b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = 16'h0030; b_req_wdata = 16'h4242;
    c0 = cyc;
    for (int i = 0; i < 4; i++) begin
      qb_data.push_back(32'h4242);
      qb_cyc.push_back(c0 + 1 + 2 * i);
    end
    for (int i = 1; i <= 7; i++) begin
      @(negedge Clk);
      if (i % 2 == 0) chk("b_ready_idle", 32'(b_req_ready), 32'd1);
    end
    b_req_valid = 1'b0;
    drain();
    req(1, 1'b0, 16'h0030, 16'h0000, 16'h4242);
    drain();

    // Reset during the wait phase of a write must abort it.
    req(0, 1'b1, 16'h0010, 16'h5555, 16'h5555);
    drain();
    @(negedge Clk);
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 16'h0010; a_req_wdata = 16'hAAAA;
    @(posedge Clk);
    #1 a_req_valid = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    chk("abort_ready", 32'(a_req_ready), 32'd1);
    chk("abort_rsp_valid", 32'(a_rsp_valid), 32'd0);
    chk("abort_hex", 32'(a_HEX_reg), 32'h0);
    chk("abort_rdata", 32'(a_rsp_rdata), 32'h0);
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (6) @(negedge Clk);
    req(0, 1'b0, 16'h0010, 16'h0000, 16'h5555);
    drain();
    chk("hex_after_abort", 32'(a_HEX_reg), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
